rca_serial_addsub: RTL and testbench

- Bit-serial, multi-cycle adder/subtractor.
- Handles the same 4-bit operand/carry interface as the combinational ripple-carry adder, in the reverse direction as well: add or subtract.
- Uses one full-adder slice and a carry/borrow flop, processing one bit per clock, LSB first.
- Used where area matters more than latency; start/done handshake toward the controlling logic.

---
 rtl/rca_serial_addsub.sv | 93 +++++++++
 tb/tb_rca_serial_addsub.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_serial_addsub.sv
// Bit-serial add/subtract: one full-adder slice plus a carry/borrow flop,
// LSB first, one bit per clock, start/done handshake.
module rca_serial_addsub #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Handshake: start is honoured only in IDLE (including the done cycle);
    // done pulses for one cycle after the last bit, and sum/co then hold
    // until the next accepted start clears them.
    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             sub_q;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic ai;
    logic bi;
    logic s_bit;
    logic c_next;

    always_comb begin
        ai     = a_sh[0];
        bi     = b_sh[0];
        s_bit  = ai ^ bi ^ c;
        c_next = sub_q ? ((~ai & bi) | (~ai & c) | (bi & c))
                       : ((ai & bi) | (ai & c) | (bi & c));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sub_q <= 1'b0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        sub_q <= sub;
                        c     <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        co    <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Result enters from the MSB side so bit 0 lands at sum[0]
                    // after WIDTH shifts.
                    sum  <= {s_bit, sum[WIDTH-1:1]};
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    c    <= c_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        co    <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_serial_addsub.sv
// Self-checking bench for rca_serial_addsub: directed add/sub vectors,
// busy rules, back-to-back operation and mid-operation reset.
module tb_rca_serial_addsub;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int TMO   = 20;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    logic [WIDTH:0] exp_q[$];
    int n_cmp;
    int n_fail;

    rca_serial_addsub #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .sum(sum), .co(co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: {co,sum}.
    function automatic logic [WIDTH:0] golden(input logic s, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y, input logic ci);
        logic [WIDTH:0] r;
        logic [WIDTH:0] yc;
        yc = {1'b0, y} + {{WIDTH{1'b0}}, ci};
        if (!s) begin
            r = {1'b0, x} + yc;
        end else begin
            r[WIDTH-1:0] = x - y - {{(WIDTH-1){1'b0}}, ci};
            r[WIDTH]     = ({1'b0, x} < yc);
        end
        return r;
    endfunction

    // Drive a one-cycle start, record the expected result, return after the accept edge.
    task automatic drive_start(input logic s, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input logic ci);
        start = 1'b1; sub = s; a = x; b = y; cin = ci;
        exp_q.push_back(golden(s, x, y, ci));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Advance until done is seen or the bound expires; cyc = edges waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < TMO);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if ({busy, done, co, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: busy=%0b done=%0b co=%0b sum=%0d, want all 0", busy, done, co, sum);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: busy=%0b done=%0b, want 0 0", busy, done);
            end
        end
    endtask

    task automatic test_vectors(input logic s);
        logic [WIDTH-1:0] va[4];
        logic [WIDTH-1:0] vb[4];
        logic             vc[4];
        logic [WIDTH:0]   e;
        int cyc;
        int n;
        if (!s) begin
            va = '{4'd3, 4'd5, 4'd15, 4'd15}; vb = '{4'd1, 4'd3, 4'd1, 4'd15};
            vc = '{1'b0, 1'b1, 1'b0, 1'b1}; n = 4;
        end else begin
            va = '{4'd5, 4'd3, 4'd0, 4'd9}; vb = '{4'd3, 4'd5, 4'd0, 4'd9};
            vc = '{1'b1, 1'b0, 1'b1, 1'b0}; n = 4;
        end
        for (int i = 0; i < n; i++) begin
            drive_start(s, va[i], vb[i], vc[i]);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_rise: busy=%0b, want 1", busy);
            end
            wait_done(cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!done || cyc != WIDTH) begin
                n_fail++;
                $display("FAIL latency sub=%0b: done=%0b after %0d cycles, want done=1 after %0d", s, done, cyc, WIDTH);
            end
            n_cmp++;
            if ({co, sum} !== e || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL result sub=%0b a=%0d b=%0d cin=%0b: co=%0b sum=%0d busy=%0b, want co=%0b sum=%0d busy=0",
                         s, va[i], vb[i], vc[i], co, sum, busy, e[WIDTH], e[WIDTH-1:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_ignore();
        logic [WIDTH:0] e;
        int cyc;
        drive_start(1'b0, 4'd10, 4'd5, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; a = 4'd1; b = 4'd1; cin = 1'b0; sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 4'd7; b = 4'd2;
        wait_done(cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!done || cyc != WIDTH - 2) begin
            n_fail++;
            $display("FAIL busy_latency: done=%0b at %0d cycles after start, want 1 at %0d", done, cyc + 2, WIDTH);
        end
        n_cmp++;
        if ({co, sum} !== e) begin
            n_fail++;
            $display("FAIL busy_result: co=%0b sum=%0d, want co=%0b sum=%0d", co, sum, e[WIDTH], e[WIDTH-1:0]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%0b in second cycle, want 0", done);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || {co, sum} !== e) begin
                n_fail++;
                $display("FAIL busy_hold: busy=%0b done=%0b co=%0b sum=%0d, want 0 0 %0b %0d",
                         busy, done, co, sum, e[WIDTH], e[WIDTH-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic [WIDTH:0] e;
        logic           s;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic           ci;
        int cyc;
        s = 1'($urandom_range(0, 1)); x = WIDTH'($urandom_range(0, 15));
        y = WIDTH'($urandom_range(0, 15)); ci = 1'($urandom_range(0, 1));
        start = 1'b1; sub = s; a = x; b = y; cin = ci;
        exp_q.push_back(golden(s, x, y, ci));
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            wait_done(cyc);
            n_cmp++;
            if (!done || cyc != (k == 0 ? WIDTH : WIDTH + 1)) begin
                n_fail++;
                $display("FAIL b2b_period op%0d: done=%0b after %0d cycles, want %0d", k, done, cyc,
                         (k == 0 ? WIDTH : WIDTH + 1));
            end
            e = exp_q.pop_front();
            n_cmp++;
            if ({co, sum} !== e) begin
                n_fail++;
                $display("FAIL b2b_result op%0d: co=%0b sum=%0d, want co=%0b sum=%0d", k, co, sum,
                         e[WIDTH], e[WIDTH-1:0]);
            end
            if (k < N - 1) begin
                s = 1'($urandom_range(0, 1)); x = WIDTH'($urandom_range(0, 15));
                y = WIDTH'($urandom_range(0, 15)); ci = 1'($urandom_range(0, 1));
                sub = s; a = x; b = y; cin = ci;
                exp_q.push_back(golden(s, x, y, ci));
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [WIDTH:0] e;
        int cyc;
        drive_start(1'b0, 4'd15, 4'd15, 1'b0);
        void'(exp_q.pop_back());
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, co, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%0b done=%0b co=%0b sum=%0d, want all 0", busy, done, co, sum);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_nodone: done=%0b busy=%0b, want 0 0", done, busy);
            end
        end
        drive_start(1'b0, 4'd1, 4'd2, 1'b0);
        wait_done(cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!done || cyc != WIDTH || {co, sum} !== e) begin
            n_fail++;
            $display("FAIL reset_restart: done=%0b cyc=%0d co=%0b sum=%0d, want 1 %0d %0b %0d",
                     done, cyc, co, sum, WIDTH, e[WIDTH], e[WIDTH-1:0]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_vectors(1'b0);
        test_vectors(1'b1);
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_empty: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
